// File: rtl/ic_pkg.sv
// Shared types and default configuration for the interrupt servicer.
package ic_pkg;

   // Service FSM states; any other encoding falls back to IDLE.
   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      PROCESSING  = 2'b01,
      ACKNOWLEDGE = 2'b10
   } state_t;

   localparam int unsigned ID_W_DEF       = 3;
   localparam int unsigned QDEPTH_DEF     = 4;
   localparam int unsigned SVC_CYCLES_DEF = 4;

   // Service counter wide enough for the largest legal SVC_CYCLES (15).
   localparam int unsigned SVC_CNT_W = 4;

endpackage

// File: rtl/ic_irq_fifo.sv
// Pending-request FIFO: power-of-two depth, naturally wrapping pointers.
// A push while full is only accepted if a pop happens at the same edge;
// otherwise it is dropped and flagged for one cycle on 'dropped'.
module ic_irq_fifo #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             dropped
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   // Accept/drop decisions and status flags.
   always_comb begin
      full     = (count_q == CW'(DEPTH));
      empty    = (count_q == '0);
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      dropped  = push && !do_push;
      pop_data = mem[rd_ptr_q];
      count    = count_q;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CW'(1);
         else if (do_pop && !do_push) count_q <= count_q - CW'(1);
      end
   end

   // Storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/ic_irq_servicer.sv
// Interrupt servicer: captures rising edges of irq_in into a FIFO, services
// each request for SVC_CYCLES cycles, then pulses ack for one cycle.
// Optional feature: define IC_SVC_STATS_EN to add the svc_cnt port holding
// one 8-bit saturating ack counter per interrupt ID.
module ic_irq_servicer
   import ic_pkg::*;
#(
   parameter int unsigned ID_W       = ID_W_DEF,
   parameter int unsigned QDEPTH     = QDEPTH_DEF,
   parameter int unsigned SVC_CYCLES = SVC_CYCLES_DEF,
   localparam int unsigned CW        = $clog2(QDEPTH + 1),
   localparam int unsigned NUM_ID    = 1 << ID_W
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            irq_in,
   input  logic [ID_W-1:0] irq_id_in,
   output logic            ack,
   output logic [ID_W-1:0] ack_id,
   output logic            busy,
   output logic [ID_W-1:0] cur_id,
   output logic [CW-1:0]   q_count,
   output logic            q_full,
   output logic            overflow
`ifdef IC_SVC_STATS_EN
   ,
   output logic [NUM_ID*8-1:0] svc_cnt
`endif
);

   state_t                 state_q, state_d;
   logic [SVC_CNT_W-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]        cur_id_q, cur_id_d;
   logic                   irq_q;
   logic                   overflow_q;
   logic                   push, pop;
   logic [ID_W-1:0]        head_id;
   logic                   fifo_empty;
   logic                   fifo_dropped;

   assign push = irq_in && !irq_q;

   ic_irq_fifo #(
      .WIDTH (ID_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .push_data (irq_id_in),
      .pop       (pop),
      .pop_data  (head_id),
      .count     (q_count),
      .full      (q_full),
      .empty     (fifo_empty),
      .dropped   (fifo_dropped)
   );

   // Edge-detect history and sticky overflow flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         irq_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         irq_q <= irq_in;
         if (fifo_dropped) overflow_q <= 1'b1;
      end
   end

   // FSM state, service counter and in-service ID.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cur_id_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cur_id_q <= cur_id_d;
      end
   end

   // Next-state and output decode; the queue is sampled by its registered
   // count, so a request pushed this edge is never popped at the same edge.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cur_id_d = cur_id_q;
      pop      = 1'b0;
      ack      = 1'b0;
      ack_id   = '0;
      busy     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               cur_id_d = head_id;
               cnt_d    = '0;
               state_d  = PROCESSING;
            end
         end
         PROCESSING: begin
            busy  = 1'b1;
            cnt_d = cnt_q + SVC_CNT_W'(1);
            if (cnt_q == SVC_CNT_W'(SVC_CYCLES - 1)) state_d = ACKNOWLEDGE;
         end
         ACKNOWLEDGE: begin
            busy   = 1'b1;
            ack    = 1'b1;
            ack_id = cur_id_q;
            if (!fifo_empty) begin
               pop      = 1'b1;
               cur_id_d = head_id;
               cnt_d    = '0;
               state_d  = PROCESSING;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cur_id   = cur_id_q;
   assign overflow = overflow_q;

`ifdef IC_SVC_STATS_EN
   logic [7:0] stat_q [NUM_ID];

   // Per-ID ack counters, saturating at 255.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(NUM_ID); i++) stat_q[i] <= '0;
      end else if (ack && (stat_q[cur_id_q] != 8'hFF)) begin
         stat_q[cur_id_q] <= stat_q[cur_id_q] + 8'd1;
      end
   end

   for (genvar g = 0; g < int'(NUM_ID); g++) begin : g_stat
      assign svc_cnt[g*8 +: 8] = stat_q[g];
   end
`endif

endmodule

// File: doc/ic_irq_servicer.md
IC_IRQ_SERVICER -- requirements
Module: ic_irq_servicer

Interface
REQ-001 Parameter ID_W, default 3: interrupt ID width; legal range 1..8.
REQ-002 Parameter QDEPTH, default 4: pending-request queue depth; power of two, 2..16.
REQ-003 Parameter SVC_CYCLES, default 4: cycles spent in PROCESSING per request; legal range 1..15.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 irq_in  in  1  interrupt request level from the controller.
REQ-007 irq_id_in  in  ID_W  ID qualifying irq_in.
REQ-008 ack  out  1  one-cycle acknowledge pulse to the controller.
REQ-009 ack_id  out  ID_W  ID being acknowledged; valid only while ack=1, otherwise 0.
REQ-010 busy  out  1  high in PROCESSING or ACKNOWLEDGE.
REQ-011 cur_id  out  ID_W  ID in service; holds its last value in IDLE.
REQ-012 q_count  out  $clog2(QDEPTH+1)  number of queued requests.
REQ-013 q_full  out  1  q_count==QDEPTH.
REQ-014 overflow  out  1  sticky; set on any dropped request.

Function
REQ-015 Capture: a request SHALL be pushed when irq_in is sampled 1 and the registered irq_in from the previous edge is 0 (rising-edge detect); the ID pushed is irq_id_in at that edge.
REQ-016 Queue: FIFO order; ID_W-bit entries; read and write pointers wrap modulo QDEPTH.
REQ-017 FSM states: IDLE, PROCESSING, ACKNOWLEDGE.
REQ-018 IDLE -> PROCESSING when q_count>0: pop the head, load cur_id, clear the service counter.
REQ-019 In PROCESSING the counter SHALL increment each cycle; transition to ACKNOWLEDGE when counter==SVC_CYCLES-1; PROCESSING lasts exactly SVC_CYCLES cycles.
REQ-020 ACKNOWLEDGE lasts one cycle, with ack=1 and ack_id=cur_id; then PROCESSING (with a pop) if q_count>0, else IDLE.
REQ-021 Latency, idle with an empty queue: ack is high in the cycle after edge T+SVC_CYCLES+1, where T is the capture edge.
REQ-022 Simultaneous push and pop: both take effect; q_count unchanged; a push to an empty queue is not popped at the same edge.
REQ-023 Push while full without a simultaneous pop: the request is dropped, overflow set, queue unchanged; a push while full with a simultaneous pop is accepted.
REQ-024 irq_in held high SHALL produce exactly one push; an ID change while high produces no push.
REQ-025 Undefined state encoding SHALL return to IDLE on the next edge.

Reset
REQ-026 On rstn=0, immediately: state=IDLE; ack=0, ack_id=0, busy=0, cur_id=0, q_count=0, q_full=0, overflow=0; pointers=0; counter=0; irq_in history=0.
REQ-027 Reset mid-service discards the current request and all queued requests; no ack is issued for them.
REQ-028 Reset is the only way to clear overflow.

Configuration
REQ-029 Macro IC_SVC_STATS_EN: when defined, adds output svc_cnt, width (2**ID_W)*8, one 8-bit saturating counter per ID, incremented on each ack for that ID, reset to 0.
REQ-030 Without IC_SVC_STATS_EN: no svc_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-031 Package ic_pkg SHALL hold the state_t enum (IDLE, PROCESSING, ACKNOWLEDGE) and the default parameter constants.
REQ-032 The queue SHALL be a sub-module ic_irq_fifo, parameterised by width and depth, with push/pop/count/full/empty.

Verification
REQ-033 Single request, default parameters: irq_in rises with ID 5 at edge 10 -> busy high after edge 11; ack=1, ack_id=5 in the cycle after edge 15 only; IDLE after edge 16.
REQ-034 Back-to-back: IDs 1, 2, 3 pushed on separate rising edges while busy -> acks in order 1, 2, 3, each separated by SVC_CYCLES+1 cycles, with no IDLE cycles between them.
REQ-035 Overflow: QDEPTH=4; six rising edges while the first request is in service -> q_full=1, one request dropped, overflow=1 stays set; 5 acks total.
REQ-036 Held level: irq_in high for 20 cycles -> exactly one ack.
REQ-037 Reset mid-PROCESSING with q_count=2: assert rstn=0 -> all outputs 0 asynchronously; no acks after release.
REQ-038 With IC_SVC_STATS_EN: 300 requests with ID 7 -> svc_cnt for ID 7 saturates at 255; other IDs read 0.
